// File: rtl/sram22_bist_pkg.sv
// Shared types and the March C- op table for the sram22 BIST controller.
package sram22_bist_pkg;

    typedef enum logic [2:0] {E_M0, E_M1, E_M2, E_M3, E_M4, E_M5} elem_e;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_e;

    localparam int RUN_CYCLES = 640;

    // Per-element behaviour; rd_val/wr_val select BG (0) or ~BG (1).
    typedef struct packed {
        logic down;
        logic has_rd;
        logic has_wr;
        logic rd_val;
        logic wr_val;
    } elem_op_t;

    function automatic elem_op_t elem_op(elem_e e);
        elem_op_t o;
        case (e)
            E_M0:    o = elem_op_t'(5'b00100);  // up(w0)
            E_M1:    o = elem_op_t'(5'b01101);  // up(r0,w1)
            E_M2:    o = elem_op_t'(5'b01110);  // up(r1,w0)
            E_M3:    o = elem_op_t'(5'b11101);  // down(r0,w1)
            E_M4:    o = elem_op_t'(5'b11110);  // down(r1,w0)
            E_M5:    o = elem_op_t'(5'b01000);  // up(r0)
            default: o = elem_op_t'(5'b00000);
        endcase
        return o;
    endfunction

endpackage

// File: rtl/sram22_march_bist_ctrl_if.sv
// Functional requester port plus SRAM macro port of the BIST controller.
interface sram22_march_bist_ctrl_if #(
    parameter int ADDR_WIDTH  = 6,
    parameter int DATA_WIDTH  = 32,
    parameter int WMASK_WIDTH = 4
);
    logic                   fn_we;
    logic [WMASK_WIDTH-1:0] fn_wmask;
    logic [ADDR_WIDTH-1:0]  fn_addr;
    logic [DATA_WIDTH-1:0]  fn_din;
    logic                   fn_ready;
    logic [DATA_WIDTH-1:0]  fn_dout;
    logic                   sram_we;
    logic [WMASK_WIDTH-1:0] sram_wmask;
    logic [ADDR_WIDTH-1:0]  sram_addr;
    logic [DATA_WIDTH-1:0]  sram_din;
    logic [DATA_WIDTH-1:0]  sram_dout;

    // Environment side: functional requester and the macro itself.
    modport master (
        output fn_we, fn_wmask, fn_addr, fn_din, sram_dout,
        input  fn_ready, fn_dout, sram_we, sram_wmask, sram_addr, sram_din
    );

    // Controller side.
    modport slave (
        input  fn_we, fn_wmask, fn_addr, fn_din, sram_dout,
        output fn_ready, fn_dout, sram_we, sram_wmask, sram_addr, sram_din
    );
endinterface

// File: rtl/sram22_bist_cmp.sv
// Read shadow, one-cycle-late compare, first-fail capture and saturating fail counter.
module sram22_bist_cmp
    import sram22_bist_pkg::*;
#(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  rd_issue,
    input  logic [DATA_WIDTH-1:0] rd_exp,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    input  elem_e                 rd_elem,
    input  logic [DATA_WIDTH-1:0] sram_dout,
    output logic                  fail,
    output logic [ADDR_WIDTH-1:0] fail_addr,
    output logic [2:0]            fail_elem,
    output logic [DATA_WIDTH-1:0] fail_xor,
    output logic [CNT_WIDTH-1:0]  fail_count
);
    logic                  sh_vld;
    logic [DATA_WIDTH-1:0] sh_exp;
    logic [ADDR_WIDTH-1:0] sh_addr;
    elem_e                 sh_elem;
    logic [DATA_WIDTH-1:0] diff;
    logic                  mism;

    assign diff = sram_dout ^ sh_exp;
    assign mism = sh_vld && (diff != '0);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            sh_vld     <= 1'b0;
            sh_exp     <= '0;
            sh_addr    <= '0;
            sh_elem    <= E_M0;
            fail       <= 1'b0;
            fail_addr  <= '0;
            fail_elem  <= '0;
            fail_xor   <= '0;
            fail_count <= '0;
        end else begin
            sh_vld <= rd_issue;
            if (rd_issue) begin
                sh_exp  <= rd_exp;
                sh_addr <= rd_addr;
                sh_elem <= rd_elem;
            end
            if (mism) begin
                fail <= 1'b1;
                // Location fields describe only the first miscompare of the run.
                if (!fail) begin
                    fail_addr <= sh_addr;
                    fail_elem <= sh_elem;
                    fail_xor  <= diff;
                end
                if (fail_count != '1)
                    fail_count <= fail_count + 1'b1;
            end
        end
    end
endmodule

// File: rtl/sram22_march_bist_ctrl.sv
// March C- BIST controller and port owner for one sram22_64x32m4w8 macro.
module sram22_march_bist_ctrl
    import sram22_bist_pkg::*;
#(
    parameter int                  ADDR_WIDTH  = 6,
    parameter int                  DATA_WIDTH  = 32,
    parameter int                  WMASK_WIDTH = 4,
    parameter logic [DATA_WIDTH-1:0] BG        = 32'h0000_0000,
    parameter int                  CNT_WIDTH   = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  fail,
    output logic [ADDR_WIDTH-1:0] fail_addr,
    output logic [2:0]            fail_elem,
    output logic [DATA_WIDTH-1:0] fail_xor,
    output logic [CNT_WIDTH-1:0]  fail_count,
    sram22_march_bist_ctrl_if.slave bus
);
    state_e                state;
    elem_e                 elem;
    elem_e                 elem_nxt;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  phase;
    elem_op_t              cur;
    elem_op_t              nxt;
    logic                  running;
    logic                  rd_op;
    logic                  wr_op;
    logic                  last_op;
    logic                  at_end;
    logic [DATA_WIDTH-1:0] bist_din;
    logic [DATA_WIDTH-1:0] rd_exp;
    logic                  accept;

    assign elem_nxt = elem_e'(elem + 3'd1);
    assign cur      = elem_op(elem);
    assign nxt      = elem_op(elem_nxt);
    assign running  = (state == S_RUN);
    // Two-op elements issue the read in phase 0 and the write in phase 1.
    assign rd_op    = running && cur.has_rd && !phase;
    assign wr_op    = running && cur.has_wr && (!cur.has_rd || phase);
    assign last_op  = !(cur.has_rd && cur.has_wr) || phase;
    assign at_end   = cur.down ? (addr == '0) : (addr == '1);
    assign bist_din = cur.wr_val ? ~BG : BG;
    assign rd_exp   = cur.rd_val ? ~BG : BG;
    assign accept   = (state == S_IDLE) && start;

    assign bus.fn_ready = !busy;
    assign bus.fn_dout  = bus.sram_dout;

    always_comb begin
        bus.sram_we    = bus.fn_we;
        bus.sram_wmask = bus.fn_wmask;
        bus.sram_addr  = bus.fn_addr;
        bus.sram_din   = bus.fn_din;
        if (busy) begin
            bus.sram_we    = wr_op;
            bus.sram_wmask = {WMASK_WIDTH{1'b1}};
            bus.sram_addr  = addr;
            bus.sram_din   = bist_din;
        end
        if (reset)
            bus.sram_we = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            elem  <= E_M0;
            addr  <= '0;
            phase <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_RUN;
                        busy  <= 1'b1;
                        done  <= 1'b0;
                        elem  <= E_M0;
                        addr  <= '0;
                        phase <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (!last_op) begin
                        phase <= 1'b1;
                    end else begin
                        phase <= 1'b0;
                        if (at_end) begin
                            if (elem == E_M5) begin
                                state <= S_DRAIN;
                            end else begin
                                elem <= elem_nxt;
                                addr <= nxt.down ? '1 : '0;
                            end
                        end else begin
                            addr <= cur.down ? addr - 1'b1 : addr + 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    // The compare of the final read completes on this same edge.
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    sram22_bist_cmp #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .CNT_WIDTH  (CNT_WIDTH)
    ) u_cmp (
        .clk        (clk),
        .reset      (reset),
        .clear      (accept),
        .rd_issue   (rd_op),
        .rd_exp     (rd_exp),
        .rd_addr    (addr),
        .rd_elem    (elem),
        .sram_dout  (bus.sram_dout),
        .fail       (fail),
        .fail_addr  (fail_addr),
        .fail_elem  (fail_elem),
        .fail_xor   (fail_xor),
        .fail_count (fail_count)
    );
endmodule

// File: doc/sram22_march_bist_ctrl.md
Name: sram22_march_bist_ctrl

Overview:
Self-test controller and port owner for one sram22_64x32m4w8 macro (64 words x 32 bits, 4 byte-lane write mask, 1-cycle registered read).
- When idle, a functional requester drives the macro directly.
- On start, the controller takes the port and runs March C- over all 64 words.
- It checks every read and reports pass/fail, the first-failure location and a saturating failure count.

Parameters:
ADDR_WIDTH, 6, SRAM address width; depth is 1<<ADDR_WIDTH
DATA_WIDTH, 32, SRAM word width
WMASK_WIDTH, 4, byte-lane mask width
BG, 32'h0000_0000, data background; "0" writes BG, "1" writes ~BG
CNT_WIDTH, 8, width of the saturating failure counter

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
start  in  1  single-cycle request to begin BIST; ignored while busy
busy  out  1  BIST owns the SRAM
done  out  1  sticky; set when a run completes, cleared by the next accepted start or by reset
fail  out  1  sticky; set on any miscompare in the current run
fail_addr  out  ADDR_WIDTH  address of the first miscompare
fail_elem  out  3  March element (0-5) of the first miscompare
fail_xor  out  DATA_WIDTH  read data XOR expected data at the first miscompare
fail_count  out  CNT_WIDTH  miscompares in the run, saturating at all-ones
fn_ready  out  1  functional port accepted (= !busy)
fn_we, fn_wmask, fn_addr, fn_din  in  1/WMASK/ADDR/DATA  functional request
fn_dout  out  DATA_WIDTH  sram_dout passthrough
sram_we, sram_wmask, sram_addr, sram_din  out  1/WMASK/ADDR/DATA  to the macro
sram_dout  in  DATA_WIDTH  from the macro

Behaviour:
- Reset values:
  - busy, done, fail = 0; fail_addr, fail_elem, fail_xor, fail_count = 0.
  - FSM goes to IDLE.
  - sram_we = 0 while reset is high.
- Port mux:
  - busy=0: sram_* equals fn_* combinationally.
  - busy=1: sram_* is driven by the BIST, and sram_wmask is all-ones on BIST writes.
  - fn_* inputs are ignored while busy; fn_dout always equals sram_dout.
- FSM states: IDLE -> RUN -> DRAIN -> IDLE.
  - IDLE: start=1 moves to RUN on the next edge. In the same edge, done, fail, fail_* and fail_count are cleared, elem=0, addr=0, phase=0.
  - RUN: one SRAM operation per cycle. The elements are:
    - M0 up(w0)
    - M1 up(r0,w1)
    - M2 up(r1,w0)
    - M3 down(r0,w1)
    - M4 down(r1,w0)
    - M5 up(r0)
  - "up" runs address 0->63; "down" runs 63->0.
  - Two-op elements alternate phase r then w at the same address, then advance the address.
  - At the last address of an element, the next element starts with addr reset to 0 (up) or 63 (down).
  - After M5 reads address 63, the FSM moves to DRAIN.
  - DRAIN: one cycle with sram_we=0 in which the final read is compared. Then done=1, busy=0, and the FSM returns to IDLE.
  - busy is high for exactly 641 cycles: 64 + 4x128 + 64 operations, plus 1 DRAIN cycle.
- Compare timing:
  - A read issued in cycle N registers expected value, address and element into a shadow with valid=1.
  - In cycle N+1, sram_dout is compared to the shadow. The result is registered at the end of N+1, even though N+1 may issue a write.
- Failure logging:
  - On a miscompare, fail is set and fail_count increments, holding at all-ones.
  - fail_addr, fail_elem and fail_xor are captured only on the first miscompare of the run.
- Simultaneous events: start while busy has no effect. A failure in the final DRAIN compare is logged before done rises.
- Reset mid-run: the run aborts the next cycle, the port returns to functional, and no done is produced.

Decomposition:
- Package sram22_bist_pkg holds:
  - element enum E_M0..E_M5 (3 bits)
  - op-table constants: direction, read value and write value per element
  - FSM state enum
  - RUN_CYCLES = 640
- Sub-module sram22_bist_cmp: read shadow register, XOR compare, first-fail capture and saturating counter.

Test Plan:
1. Fault-free model, pulse start -> busy high for 641 cycles, then done=1, fail=0, fail_count=0; final memory is all BG.
2. Model bit 3 of address 5 stuck at 1 -> fail=1, fail_addr=5, fail_elem=1, fail_xor=32'h0000_0008, fail_count=3 (from M1, M3, M5).
3. Model bit 31 of address 63 stuck at 0 -> fail_addr=63, fail_elem=2, fail_xor=32'h8000_0000, fail_count=2.
4. Idle functional traffic: write 32'hDEADBEEF to address 7 with wmask 4'b0101, then read -> fn_dout=32'h00AD00EF one cycle later. Start is then pulsed, and fn_we asserted during the run does not reach the macro.
5. Assert reset at cycle 200 of a run -> next cycle busy=0, done=0, sram_we follows fn_we. A subsequent start runs a full 641 cycles.
6. Stuck-at on all bits of 100 reads, with CNT_WIDTH=4 -> fail_count saturates at 4'hF; start pulsed mid-run is ignored, and done is cleared only by the next start.
